ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one synchronous RAM port among NUM_CLIENTS requesters, such as CPU and VGA logic running on a common clock.
- Uses round-robin arbitration, a per-client req/ack handshake, and pipelined read-return tagging.
- Sits between the clients and one port of the on-chip dual-port RAM.
- Replaces hard-wiring each client to a dedicated RAM port.

Parameters:
- NUM_CLIENTS, 2: number of requesters, 1..8.
- ADDR_WIDTH, 16: RAM word address width.
- DATA_WIDTH, 8: RAM data width.
- RD_LATENCY, 3: clock edges from the acceptance edge to valid ram_q; range 1..8.

Ports:
- clock  in  1: single clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high reset.
- req  in  NUM_CLIENTS: per-client request.
- wren  in  NUM_CLIENTS: per-client write enable; qualified by req.
- address  in  NUM_CLIENTS*ADDR_WIDTH: client i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- data  in  NUM_CLIENTS*DATA_WIDTH: per-client write data, same slicing.
- ack  out  NUM_CLIENTS: combinational grant, one-hot or zero.
- rvalid  out  NUM_CLIENTS: read-return strobe, one-hot or zero.
- rdata  out  DATA_WIDTH: read data, equal to ram_q; valid only when some rvalid bit is high.
- ram_address  out  ADDR_WIDTH: registered RAM address.
- ram_data  out  DATA_WIDTH: registered RAM write data.
- ram_wren  out  1: registered RAM write enable.
- ram_q  in  DATA_WIDTH: RAM read data.

Behaviour:
- Clock and reset:
  - One clock domain, clock.
  - reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset values:
  - ptr=0; ram_address=0; ram_data=0; ram_wren=0.
  - Read pipeline cleared; rvalid=0.
  - ack is combinational; it is forced to 0 while reset is high.
- Arbitration (combinational, every cycle):
  - Search req from index ptr upward, wrapping from NUM_CLIENTS-1 to 0.
  - The first set bit wins; ack[winner]=1.
  - If no req bit is set, ack=0.
- Acceptance:
  - A transaction is accepted at the rising edge where req[i]&ack[i]=1.
  - At that edge:
    - ram_address <= address slice i;
    - ram_data <= data slice i;
    - ram_wren <= wren[i];
    - ptr <= (i+1) mod NUM_CLIENTS, wrapping NUM_CLIENTS-1 to 0.
  - With no acceptance: ram_wren <= 0; ram_address, ram_data and ptr hold.
- Client rules:
  - Hold req, wren, address and data stable until ack is seen.
  - Back-to-back requests are legal: keeping req high after an ack issues a new transaction.
  - At most one access per clock in total.
- Read return:
  - For an accepted read (wren[i]=0), a RD_LATENCY-deep shift register carries valid plus client index.
  - rvalid[i] is high for exactly one cycle: the cycle following the edge RD_LATENCY edges after acceptance.
  - rdata = ram_q in that cycle.
  - Writes produce no rvalid.
  - Reads stay in acceptance order; a new read can issue every cycle, with no stall.
- Fairness:
  - With all clients requesting continuously, grants rotate 0,1,...,N-1,0,...
  - A requesting client waits at most NUM_CLIENTS-1 cycles.
- NUM_CLIENTS=1: ptr stays 0; ack[0]=req[0].
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is issued for them after reset.
  - ram_wren is 0 in the cycle after the reset edge.
- Simultaneous reset and req: reset wins; no acceptance and no ptr change.

Optional Feature:
- Macro: RAM_ARB_CLIENT0_PRIORITY_EN.
- Defined:
  - Client 0 has strict priority: if req[0]=1, ack[0]=1 regardless of ptr.
  - Otherwise round-robin runs over clients 1..N-1 only, and ptr ranges 1..N-1.
  - Used for the latency-critical CPU port.
- Undefined: pure round-robin over all clients as above.

Test Plan:
- Reset then idle, N=2: after reset is deasserted, ram_wren=0, ack=0, rvalid=0 and ram_address=0 for 10 cycles.
- Single write then read, client 1: write addr 0x0010 data 0xA5, then read 0x0010 → rvalid[1] exactly 3 edges after the read acceptance, rdata=0xA5, rvalid[0]=0.
- Contention, N=4: all req held high for 8 cycles → ack sequence 0,1,2,3,0,1,2,3; ptr wraps 3 to 0.
- Pipelined reads: client 0 reads addresses 0..5 on consecutive cycles → six consecutive rvalid[0] pulses with data in order, no gaps.
- Reset mid-read: issue reads, assert reset 1 edge after acceptance → no rvalid pulses follow; next read after reset returns correctly.
- With RAM_ARB_CLIENT0_PRIORITY_EN: req[0] and req[1] held high → ack[0] every cycle, ack[1]=0; drop req[0] → ack[1] the same cycle.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: client-side handshake bundle plus the shared RAM port.
// slave is the arbiter's view; master is the clients/RAM side.
interface ram_port_arbiter_if #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 8
);
   logic [NUM_CLIENTS-1:0]            req;
   logic [NUM_CLIENTS-1:0]            wren;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] data;
   logic [NUM_CLIENTS-1:0]            ack;
   logic [NUM_CLIENTS-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]             rdata;
   logic [ADDR_WIDTH-1:0]             ram_address;
   logic [DATA_WIDTH-1:0]             ram_data;
   logic                              ram_wren;
   logic [DATA_WIDTH-1:0]             ram_q;

   modport slave (
      input  req, wren, address, data, ram_q,
      output ack, rvalid, rdata, ram_address, ram_data, ram_wren
   );

   modport master (
      output req, wren, address, data, ram_q,
      input  ack, rvalid, rdata, ram_address, ram_data, ram_wren
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port among NUM_CLIENTS requesters
// with round-robin grant, req/ack handshake and tagged pipelined read return.
// Optional macro RAM_ARB_CLIENT0_PRIORITY_EN: client 0 gets strict priority and
// the round-robin pointer covers clients 1..NUM_CLIENTS-1 only.
module ram_port_arbiter #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned RD_LATENCY  = 3
) (
   input logic               clock,
   input logic               reset,
   ram_port_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
`ifdef RAM_ARB_CLIENT0_PRIORITY_EN
   localparam int unsigned RR_FIRST = (NUM_CLIENTS > 1) ? 1 : 0;
`else
   localparam int unsigned RR_FIRST = 0;
`endif
   localparam int unsigned       RR_COUNT = NUM_CLIENTS - RR_FIRST;
   localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(RR_FIRST);

   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0]  ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0]  ram_data_q, ram_data_d;
   logic                   ram_wren_q, ram_wren_d;
   logic [RD_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
   logic [PTR_W-1:0]       pipe_cli_q [RD_LATENCY];
   logic [PTR_W-1:0]       pipe_cli_d [RD_LATENCY];
   logic [NUM_CLIENTS-1:0] rvalid_q, rvalid_d;

   logic                   found_c;
   logic [PTR_W-1:0]       win_c;
   logic [NUM_CLIENTS-1:0] grant_c;
   logic [ADDR_WIDTH-1:0]  sel_addr_c;
   logic [DATA_WIDTH-1:0]  sel_data_c;
   logic                   sel_wren_c;
   logic                   adv_c;
   int unsigned            idx_c;

   // Grant search: first requester at or after ptr (wrapping); nothing while in reset.
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      grant_c = '0;
      idx_c   = 0;
      if (!reset) begin
`ifdef RAM_ARB_CLIENT0_PRIORITY_EN
         if (bus.req[0]) begin
            found_c = 1'b1;
         end
`endif
         for (int unsigned k = 0; k < RR_COUNT; k++) begin
            idx_c = 32'(ptr_q) + k;
            if (idx_c >= NUM_CLIENTS) begin
               idx_c = idx_c - RR_COUNT;
            end
            if (!found_c && bus.req[PTR_W'(idx_c)]) begin
               found_c = 1'b1;
               win_c   = PTR_W'(idx_c);
            end
         end
      end
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         grant_c[i] = found_c && (win_c == PTR_W'(i));
      end
   end

   // Route the winning client's request fields.
   always_comb begin
      sel_addr_c = '0;
      sel_data_c = '0;
      sel_wren_c = 1'b0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (win_c == PTR_W'(i)) begin
            sel_addr_c = bus.address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data_c = bus.data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_wren_c = bus.wren[i];
         end
      end
   end

   // Only round-robin clients move the pointer; client 0 holds it when it has priority.
   always_comb begin
`ifdef RAM_ARB_CLIENT0_PRIORITY_EN
      adv_c = (win_c != '0) || (NUM_CLIENTS == 1);
`else
      adv_c = 1'b1;
`endif
   end

   // Next state: RAM port capture, pointer advance, read-tag shift and rvalid decode.
   always_comb begin
      ptr_d         = ptr_q;
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      ram_wren_d    = 1'b0;
      pipe_vld_d    = '0;
      pipe_cli_d    = pipe_cli_q;
      rvalid_d      = '0;
      if (found_c) begin
         ram_address_d = sel_addr_c;
         ram_data_d    = sel_data_c;
         ram_wren_d    = sel_wren_c;
         if (adv_c) begin
            if (32'(win_c) == NUM_CLIENTS - 1) begin
               ptr_d = PTR_RST;
            end else begin
               ptr_d = win_c + PTR_W'(1);
            end
         end
      end
      pipe_vld_d[0] = found_c & ~sel_wren_c;
      pipe_cli_d[0] = win_c;
      for (int unsigned k = 1; k < RD_LATENCY; k++) begin
         pipe_vld_d[k] = pipe_vld_q[k-1];
         pipe_cli_d[k] = pipe_cli_q[k-1];
      end
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         rvalid_d[i] = pipe_vld_q[RD_LATENCY-1] && (pipe_cli_q[RD_LATENCY-1] == PTR_W'(i));
      end
   end

   // State registers; reset discards in-flight reads.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q         <= PTR_RST;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         ram_wren_q    <= 1'b0;
         pipe_vld_q    <= '0;
         rvalid_q      <= '0;
         for (int unsigned k = 0; k < RD_LATENCY; k++) begin
            pipe_cli_q[k] <= '0;
         end
      end else begin
         ptr_q         <= ptr_d;
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         ram_wren_q    <= ram_wren_d;
         pipe_vld_q    <= pipe_vld_d;
         rvalid_q      <= rvalid_d;
         for (int unsigned k = 0; k < RD_LATENCY; k++) begin
            pipe_cli_q[k] <= pipe_cli_d[k];
         end
      end
   end

   assign bus.ack         = grant_c;
   assign bus.rvalid      = rvalid_q;
   assign bus.rdata       = bus.ram_q;
   assign bus.ram_address = ram_address_q;
   assign bus.ram_data    = ram_data_q;
   assign bus.ram_wren    = ram_wren_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed stimulus for ram_port_arbiter,
// checked against a transaction-level model (grant rule, memory map, read queue).
module tb_ram_port_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned L  = 3;

`ifdef RAM_ARB_CLIENT0_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   localparam int RR_LO = (PRIO && N > 1) ? 1 : 0;
   localparam int RR_N  = N - RR_LO;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ram_port_arbiter_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_port_arbiter #(
      .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Synchronous RAM with L edges from address capture to output.
   logic [DW-1:0] ram_mem  [1<<AW];
   logic [DW-1:0] ram_pipe [L];
   always @(posedge clock) begin
      ram_pipe[0] <= ram_mem[bus.ram_address];
      for (int k = 1; k < L; k++) ram_pipe[k] <= ram_pipe[k-1];
      if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data;
   end
   assign bus.ram_q = ram_pipe[L-1];

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(a ^ (a >> 8) ^ 8'h5A);
   endfunction

   // Client request state.
   logic          pend  [N];
   logic          cwr   [N];
   logic [AW-1:0] caddr [N];
   logic [DW-1:0] cdat  [N];

   // Reference model.
   typedef struct {
      int            cli;
      logic [DW-1:0] dat;
      int            due;
   } rd_t;
   rd_t           rq [$];
   logic [DW-1:0] m_mem [int];
   int            m_ptr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_wren;
   int            cyc;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int model_winner(input logic [N-1:0] r, input int p);
      if (PRIO && r[0]) return 0;
      for (int k = 0; k < RR_N; k++) begin
         int c;
         c = RR_LO + ((p - RR_LO + k) % RR_N);
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // One clock: drive, check ack mid-cycle, clock edge, check registered outputs.
   task automatic step();
      logic [N-1:0] r;
      logic [N-1:0] ea;
      logic [N-1:0] erv;
      int           w;
      for (int i = 0; i < N; i++) begin
         bus.req[i]            = pend[i];
         bus.wren[i]           = cwr[i];
         bus.address[i*AW +: AW] = caddr[i];
         bus.data[i*DW +: DW]    = cdat[i];
      end
      @(negedge clock);
      r  = bus.req;
      w  = reset ? -1 : model_winner(r, m_ptr);
      ea = '0;
      if (w >= 0) ea[w] = 1'b1;
      check_val("ack", 32'(bus.ack), 32'(ea));
      @(posedge clock);
      cyc++;
      if (reset) begin
         m_ptr  = RR_LO;
         m_addr = '0;
         m_data = '0;
         m_wren = 1'b0;
         rq.delete();
      end else begin
         m_wren = 1'b0;
         if (w >= 0) begin
            rd_t t;
            m_addr = caddr[w];
            m_data = cdat[w];
            m_wren = cwr[w];
            if (cwr[w]) begin
               m_mem[int'(caddr[w])] = cdat[w];
            end else begin
               t.cli = w;
               t.dat = m_mem.exists(int'(caddr[w])) ? m_mem[int'(caddr[w])] : init_val(int'(caddr[w]));
               t.due = cyc + L;
               rq.push_back(t);
            end
            if (w >= RR_LO) m_ptr = RR_LO + ((w - RR_LO + 1) % RR_N);
            pend[w] = 1'b0;
         end
      end
      #1;
      check_val("ram_wren", 32'(bus.ram_wren), 32'(m_wren));
      check_val("ram_address", 32'(bus.ram_address), 32'(m_addr));
      check_val("ram_data", 32'(bus.ram_data), 32'(m_data));
      erv = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         erv[rq[0].cli] = 1'b1;
         check_val("rdata", 32'(bus.rdata), 32'(rq[0].dat));
         void'(rq.pop_front());
      end
      check_val("rvalid", 32'(bus.rvalid), 32'(erv));
   endtask

   task automatic new_txn(input int c);
      pend[c]  = 1'b1;
      cwr[c]   = 1'($urandom_range(0, 1));
      caddr[c] = AW'($urandom_range(0, 15));
      cdat[c]  = DW'($urandom);
   endtask

   task automatic issue(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      pend[c]  = 1'b1;
      cwr[c]   = w;
      caddr[c] = a;
      cdat[c]  = d;
      n = 0;
      while (pend[c] && n < 4*N) begin
         step();
         n++;
      end
      check_val("accepted", 32'(pend[c]), 32'd0);
      pend[c] = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) step();
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) ram_mem[a] = init_val(a);
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; cwr[i] = 1'b0; caddr[i] = '0; cdat[i] = '0;
      end
      cyc = 0; m_ptr = RR_LO; m_addr = '0; m_data = '0; m_wren = 1'b0;

      // Reset, then idle.
      reset = 1'b1;
      drain(3);
      reset = 1'b0;
      drain(10);

      // Write then read back on client 1.
      issue(1, 1'b1, 16'h0010, 8'hA5);
      issue(1, 1'b0, 16'h0010, 8'h00);
      drain(L + 2);

      // All clients contending.
      for (int i = 0; i < N; i++) new_txn(i);
      repeat (8) begin
         step();
         for (int i = 0; i < N; i++) if (!pend[i]) new_txn(i);
      end
      drain(2*N + L + 2);

      // Back-to-back reads on client 0.
      for (int k = 0; k < 6; k++) issue(0, 1'b0, AW'(k), 8'h00);
      drain(L + 2);

`ifdef RAM_ARB_CLIENT0_PRIORITY_EN
      // Client 0 holds priority over a continuously requesting client 1.
      repeat (6) begin
         if (!pend[0]) new_txn(0);
         if (!pend[1]) new_txn(1);
         step();
      end
      drain(N + L + 2);
`endif

      // Reset one edge after a read is accepted.
      issue(2, 1'b0, 16'h0005, 8'h00);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drain(L + 3);
      issue(2, 1'b0, 16'h0005, 8'h00);
      drain(L + 2);

      // Random traffic with occasional reset.
      repeat (300) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 40) new_txn(i);
         end
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      drain(4*N + L + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
